vga_timing_gen: RTL and testbench

- Parametrised successor of the fixed 640x480@60Hz sync generator.
- Timing, sync polarity, counter width and active-video lead are all parameters.
- Adds a pixel-clock enable, a zero-skew registered output bundle, line/frame start strobes and a frame counter.
- Sits between the pixel clock domain and the framebuffer/text-mode fetch logic; the lead output lets fetch pipelines prefetch.

---
 rtl/vga_timing_if.sv | 32 +++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Video timing bundle from the sync generator
// to fetch/scan-out logic.
interface vga_timing_if #(
  parameter int CNT_W = 10,
  parameter int FC_W  = 8
);
  logic             hsync_o;
  logic             vsync_o;
  logic [CNT_W-1:0] hc_o;
  logic [CNT_W-1:0] vc_o;
  logic [CNT_W-1:0] x_px_o;
  logic [CNT_W-1:0] y_px_o;
  logic             activevideo_o;
  logic             prefetch_o;
  logic             line_start_o;
  logic             frame_start_o;
  logic [FC_W-1:0]  frame_cnt_o;

  modport master (
    output hsync_o, vsync_o, hc_o, vc_o,
    output x_px_o, y_px_o, activevideo_o,
    output prefetch_o, line_start_o,
    output frame_start_o, frame_cnt_o
  );

  modport slave (
    input hsync_o, vsync_o, hc_o, vc_o,
    input x_px_o, y_px_o, activevideo_o,
    input prefetch_o, line_start_o,
    input frame_start_o, frame_cnt_o
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator with zero-skew
// registered outputs decoded from next-state counters.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10,
  parameter int LEAD     = 1,
  parameter int FC_W     = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         en_i,
  vga_timing_if.master vid
);

  localparam int BLACK_H = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = BLACK_H + H_ACTIVE;
  localparam int BLACK_V = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = BLACK_V + V_ACTIVE;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [FC_W-1:0]  fc_t;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  if ((H_TOTAL - 1) >= (1 << CNT_W) ||
      (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_w
    $fatal(1, "counter width too small");
  end
  if (LEAD < 0 || LEAD >= BLACK_H) begin : g_bad_lead
    $fatal(1, "LEAD out of range");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $fatal(1, "sync width must be >= 1");
  end

  cnt_t hc_q, vc_q, x_q, y_q;
  cnt_t hc_n, vc_n, x_n, y_n;
  fc_t  fc_q, fc_n;
  logic hs_q, vs_q, av_q, pf_q, ls_q, fs_q;
  logic hs_n, vs_n, av_n, pf_n, ls_n, fs_n;
  int   h, v;

  // Next counter values and the decode of them.
  always_comb begin
    hc_n = hc_q + cnt_t'(1);
    vc_n = vc_q;
    fc_n = fc_q;
    if (hc_q == H_LAST) begin
      hc_n = '0;
      vc_n = vc_q + cnt_t'(1);
      if (vc_q == V_LAST) begin
        vc_n = '0;
        fc_n = fc_q + fc_t'(1);
      end
    end
    h    = int'(hc_n);
    v    = int'(vc_n);
    hs_n = (h >= H_FP && h < H_FP + H_SYNC)
           ? HS_POL : ~HS_POL;
    vs_n = (v >= V_FP && v < V_FP + V_SYNC)
           ? VS_POL : ~VS_POL;
    av_n = (h >= BLACK_H) && (v >= BLACK_V);
    pf_n = (h >= BLACK_H - LEAD) &&
           (h < H_TOTAL - LEAD) &&
           (v >= BLACK_V);
    x_n  = av_n ? cnt_t'(h - BLACK_H) : '0;
    y_n  = av_n ? cnt_t'(v - BLACK_V) : '0;
    ls_n = (hc_n == '0);
    fs_n = (hc_n == '0) && (vc_n == '0);
  end

  // Register counters and decoded outputs together.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hc_q <= '0;
      vc_q <= '0;
      fc_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      av_q <= 1'b0;
      pf_q <= 1'b0;
      ls_q <= 1'b1;
      fs_q <= 1'b1;
    end else if (en_i) begin
      hc_q <= hc_n;
      vc_q <= vc_n;
      fc_q <= fc_n;
      x_q  <= x_n;
      y_q  <= y_n;
      hs_q <= hs_n;
      vs_q <= vs_n;
      av_q <= av_n;
      pf_q <= pf_n;
      ls_q <= ls_n;
      fs_q <= fs_n;
    end
  end

  assign vid.hc_o          = hc_q;
  assign vid.vc_o          = vc_q;
  assign vid.x_px_o        = x_q;
  assign vid.y_px_o        = y_q;
  assign vid.hsync_o       = hs_q;
  assign vid.vsync_o       = vs_q;
  assign vid.activevideo_o = av_q;
  assign vid.prefetch_o    = pf_q;
  assign vid.line_start_o  = ls_q;
  assign vid.frame_start_o = fs_q;
  assign vid.frame_cnt_o   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen over several
// parameter sets sharing one clock, enable and reset.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.CNT_W(10), .FC_W(8)) mi();
  vga_timing_if #(.CNT_W(10), .FC_W(8)) pi();
  vga_timing_if #(.CNT_W(4),  .FC_W(8)) si();
  vga_timing_if #(.CNT_W(4),  .FC_W(2)) fi();
  vga_timing_if #(.CNT_W(10), .FC_W(8)) ti();

  vga_timing_gen u_m (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .vid(mi)
  );

  vga_timing_gen #(
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_p (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .vid(pi)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CNT_W(4), .LEAD(2), .FC_W(8)
  ) u_s (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .vid(si)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CNT_W(4), .LEAD(2), .FC_W(2)
  ) u_f (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .vid(fi)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1)
  ) u_t (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .vid(ti)
  );

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    int hs_f, hs_l, vs_f, vs_l, av_h, av_v;
    int x799, y45;
    int phs_f, phs_l, pvs_f, pvs_l;
    int spf_f, spf_l, sav_f, sav_l;
    int sx7, sx14, s_early;
    int fcs[4];
    int tx, ty, tvc, thc, tfc, tfs, thc0;
    hs_f = -1; hs_l = -1; vs_f = -1; vs_l = -1;
    av_h = -1; av_v = -1; x799 = -1; y45 = -1;
    phs_f = -1; phs_l = -1; pvs_f = -1; pvs_l = -1;
    spf_f = -1; spf_l = -1; sav_f = -1; sav_l = -1;
    sx7 = -1; sx14 = -1; s_early = 0;
    foreach (fcs[i]) fcs[i] = -1;
    tx = -1; ty = -1; tvc = -1; thc = -1;
    tfc = -1; tfs = -1; thc0 = -1;

    rstn = 1'b0;
    en   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hc", mi.hc_o, 0);
    chk("rst_vc", mi.vc_o, 0);
    chk("rst_x", mi.x_px_o, 0);
    chk("rst_y", mi.y_px_o, 0);
    chk("rst_av", mi.activevideo_o, 0);
    chk("rst_pf", mi.prefetch_o, 0);
    chk("rst_hs", mi.hsync_o, 1);
    chk("rst_vs", mi.vsync_o, 1);
    chk("rst_ls", mi.line_start_o, 1);
    chk("rst_fs", mi.frame_start_o, 1);
    chk("rst_fc", mi.frame_cnt_o, 0);
    chk("rst_pol_hs", pi.hsync_o, 0);
    chk("rst_pol_vs", pi.vsync_o, 0);

    rstn = 1'b1;
    for (int t = 0; t < 37200; t++) begin
      if (mi.vc_o == 0 && mi.hsync_o == 1'b0) begin
        if (hs_f < 0) hs_f = int'(mi.hc_o);
        hs_l = int'(mi.hc_o);
      end
      if (mi.hc_o == 0 && mi.vsync_o == 1'b0) begin
        if (vs_f < 0) vs_f = int'(mi.vc_o);
        vs_l = int'(mi.vc_o);
      end
      if (mi.activevideo_o && av_h < 0) begin
        av_h = int'(mi.hc_o);
        av_v = int'(mi.vc_o);
      end
      if (mi.vc_o == 45 && mi.hc_o == 799) begin
        x799 = int'(mi.x_px_o);
        y45  = int'(mi.y_px_o);
      end
      if (pi.vc_o == 0 && pi.hsync_o == 1'b1) begin
        if (phs_f < 0) phs_f = int'(pi.hc_o);
        phs_l = int'(pi.hc_o);
      end
      if (pi.hc_o == 0 && pi.vsync_o == 1'b1) begin
        if (pvs_f < 0) pvs_f = int'(pi.vc_o);
        pvs_l = int'(pi.vc_o);
      end
      if (t < 120) begin
        if (si.vc_o < 4 && si.prefetch_o) s_early++;
        if (si.vc_o == 4) begin
          if (si.prefetch_o) begin
            if (spf_f < 0) spf_f = int'(si.hc_o);
            spf_l = int'(si.hc_o);
          end
          if (si.activevideo_o) begin
            if (sav_f < 0) sav_f = int'(si.hc_o);
            sav_l = int'(si.hc_o);
          end
          if (si.hc_o == 7)  sx7  = int'(si.x_px_o);
          if (si.hc_o == 14) sx14 = int'(si.x_px_o);
        end
      end
      if (t > 0 && t <= 480 && t % 120 == 0)
        fcs[t/120-1] = int'(fi.frame_cnt_o);
      if (t == 3674) begin
        tx  = int'(ti.x_px_o);
        ty  = int'(ti.y_px_o);
        tvc = int'(ti.vc_o);
        thc = int'(ti.hc_o);
      end
      if (t == 3675) begin
        tfc  = int'(ti.frame_cnt_o);
        tfs  = int'(ti.frame_start_o);
        thc0 = int'(ti.hc_o);
      end
      @(negedge clk);
    end

    chk("hs_low_first", hs_f, 16);
    chk("hs_low_last", hs_l, 111);
    chk("vs_low_first", vs_f, 10);
    chk("vs_low_last", vs_l, 11);
    chk("av_first_hc", av_h, 160);
    chk("av_first_vc", av_v, 45);
    chk("x_at_799", x799, 639);
    chk("y_at_vc45", y45, 0);
    chk("pol_hs_first", phs_f, 16);
    chk("pol_hs_last", phs_l, 111);
    chk("pol_vs_first", pvs_f, 10);
    chk("pol_vs_last", pvs_l, 11);
    chk("s_pf_first", spf_f, 5);
    chk("s_pf_last", spf_l, 12);
    chk("s_av_first", sav_f, 7);
    chk("s_av_last", sav_l, 14);
    chk("s_x_hc7", sx7, 0);
    chk("s_x_hc14", sx14, 7);
    chk("s_pf_blank", s_early, 0);
    chk("fc_frame1", fcs[0], 1);
    chk("fc_frame2", fcs[1], 2);
    chk("fc_frame3", fcs[2], 3);
    chk("fc_frame4", fcs[3], 0);
    chk("t_last_hc", thc, 6);
    chk("t_last_vc", tvc, 524);
    chk("t_last_x", tx, 3);
    chk("t_last_y", ty, 479);
    chk("t_wrap_fc", tfc, 1);
    chk("t_wrap_fs", tfs, 1);
    chk("t_wrap_hc", thc0, 0);

    repeat (559) @(negedge clk);
    chk("stall_hc159", mi.hc_o, 159);
    @(negedge clk);
    chk("stall_hc160", mi.hc_o, 160);
    chk("stall_av0", mi.activevideo_o, 1);
    chk("stall_x0", mi.x_px_o, 0);
    en = 1'b0;
    @(negedge clk);
    chk("stall_hold1_hc", mi.hc_o, 160);
    chk("stall_hold1_av", mi.activevideo_o, 1);
    chk("stall_hold1_x", mi.x_px_o, 0);
    @(negedge clk);
    chk("stall_hold2_hc", mi.hc_o, 160);
    chk("stall_hold2_av", mi.activevideo_o, 1);
    chk("stall_hold2_x", mi.x_px_o, 0);
    en = 1'b1;
    @(negedge clk);
    chk("stall_go_hc", mi.hc_o, 161);
    chk("stall_go_x", mi.x_px_o, 1);

    repeat (2639) @(negedge clk);
    chk("pre_rst_hc", mi.hc_o, 400);
    chk("pre_rst_vc", mi.vc_o, 50);
    chk("pre_rst_x", mi.x_px_o, 240);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_hc", mi.hc_o, 0);
    chk("mid_rst_vc", mi.vc_o, 0);
    chk("mid_rst_x", mi.x_px_o, 0);
    chk("mid_rst_y", mi.y_px_o, 0);
    chk("mid_rst_av", mi.activevideo_o, 0);
    chk("mid_rst_pf", mi.prefetch_o, 0);
    chk("mid_rst_hs", mi.hsync_o, 1);
    chk("mid_rst_vs", mi.vsync_o, 1);
    chk("mid_rst_ls", mi.line_start_o, 1);
    chk("mid_rst_fs", mi.frame_start_o, 1);
    @(negedge clk);
    rstn = 1'b1;
    chk("rel_fs", mi.frame_start_o, 1);
    chk("rel_hc", mi.hc_o, 0);
    chk("rel_vc", mi.vc_o, 0);
    @(negedge clk);
    chk("rel_step_hc", mi.hc_o, 1);
    chk("rel_step_fs", mi.frame_start_o, 0);
    chk("rel_step_ls", mi.line_start_o, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
